game_ctrl: RTL and testbench



---
 rtl/game_ctrl.sv | 145 ++++++++++++++
 tb/tb_game_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Dinosaur runner game controller: IDLE/RUN/OVER sequencing, BCD score and
// high score, scroll speed ramp and restart hold-off after a collision.
module game_ctrl #(
  parameter int SCORE_DIV  = 6,
  parameter int SPEED_INIT = 4,
  parameter int SPEED_MAX  = 12,
  parameter int OVER_HOLD  = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_jump,
  input  logic        hit,
  output logic        game_status,
  output logic        game_over,
  output logic [3:0]  speed,
  output logic [15:0] score,
  output logic [15:0] hi_score,
  output logic        start_pulse
);

  localparam int DIV_W  = $clog2(SCORE_DIV + 1);
  localparam int HOLD_W = $clog2(OVER_HOLD + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCORE_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_FULL = HOLD_W'(OVER_HOLD);
  localparam logic [3:0]        SPD_INIT  = 4'(SPEED_INIT);
  localparam logic [3:0]        SPD_MAX   = 4'(SPEED_MAX);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t             state_q, state_d;
  logic [15:0]        score_q, score_d;
  logic [15:0]        hi_q, hi_d;
  logic [3:0]         speed_q, speed_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               btn_prev;
  logic               start_d;
  logic               status_q, over_q, start_q;
  logic               press;
  logic               start_run;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      score_q  <= '0;
      hi_q     <= '0;
      speed_q  <= SPD_INIT;
      div_q    <= '0;
      hold_q   <= '0;
      btn_prev <= 1'b0;
      status_q <= 1'b0;
      over_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      hi_q     <= hi_d;
      speed_q  <= speed_d;
      div_q    <= div_d;
      hold_q   <= hold_d;
      btn_prev <= btn_jump;
      status_q <= (state_d == RUN);
      over_q   <= (state_d == OVER);
      start_q  <= start_d;
    end
  end

  // Hit takes priority over a coinciding score tick; entry to RUN from IDLE
  // and from OVER shares the same re-seed actions.
  always_comb begin
    press     = btn_jump & ~btn_prev;
    state_d   = state_q;
    score_d   = score_q;
    hi_d      = hi_q;
    speed_d   = speed_q;
    div_d     = div_q;
    hold_d    = hold_q;
    start_d   = 1'b0;
    start_run = 1'b0;
    case (state_q)
      IDLE: begin
        if (press) start_run = 1'b1;
      end
      RUN: begin
        if (hit) begin
          state_d = OVER;
          hold_d  = '0;
          if (score_q > hi_q) hi_d = score_q;
        end else if (frame_tick) begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (score_q != 16'h9999) begin
              score_d = bcd_inc(score_q);
              if (score_q[7:0] == 8'h99 && speed_q < SPD_MAX)
                speed_d = speed_q + 4'd1;
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
      OVER: begin
        if (press && hold_q == HOLD_FULL)
          start_run = 1'b1;
        else if (frame_tick && hold_q != HOLD_FULL)
          hold_d = hold_q + HOLD_W'(1);
      end
      default: state_d = IDLE;
    endcase
    if (start_run) begin
      state_d = RUN;
      start_d = 1'b1;
      score_d = '0;
      speed_d = SPD_INIT;
      div_d   = '0;
    end
  end

  assign game_status = status_q;
  assign game_over   = over_q;
  assign start_pulse = start_q;
  assign score       = score_q;
  assign hi_score    = hi_q;
  assign speed       = speed_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Randomized bench for game_ctrl: two instances (default score divider and a
// divider of 1 so the 9999 ceiling is reachable) checked against a points model.
module tb_game_ctrl;

  localparam int SPEED_INIT = 4;
  localparam int SPEED_MAX  = 12;
  localparam int OVER_HOLD  = 30;
  localparam int DIV_A      = 6;
  localparam int DIV_B      = 1;

  logic        clk = 1'b0;
  logic        rst, frame_tick, btn_jump, hit;
  logic        status_a, over_a, sp_a, status_b, over_b, sp_b;
  logic [3:0]  speed_a, speed_b;
  logic [15:0] score_a, hi_a, score_b, hi_b;

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 run, 2 over; score derived from ticks counted in RUN
  int m_state[2];
  int m_ticks[2];
  int m_hi[2];
  int m_hold[2];
  bit m_sp[2];
  bit m_prev;

  always #5 clk = ~clk;

  game_ctrl #(.SCORE_DIV(DIV_A), .SPEED_INIT(SPEED_INIT), .SPEED_MAX(SPEED_MAX),
              .OVER_HOLD(OVER_HOLD)) dut_a (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_jump(btn_jump), .hit(hit),
    .game_status(status_a), .game_over(over_a), .speed(speed_a), .score(score_a),
    .hi_score(hi_a), .start_pulse(sp_a));

  game_ctrl #(.SCORE_DIV(DIV_B), .SPEED_INIT(SPEED_INIT), .SPEED_MAX(SPEED_MAX),
              .OVER_HOLD(OVER_HOLD)) dut_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_jump(btn_jump), .hit(hit),
    .game_status(status_b), .game_over(over_b), .speed(speed_b), .score(score_b),
    .hi_score(hi_b), .start_pulse(sp_b));

  function automatic int to_bcd(input int v);
    return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
           (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic int points(input int i);
    int p;
    p = m_ticks[i] / ((i == 0) ? DIV_A : DIV_B);
    return (p > 9999) ? 9999 : p;
  endfunction

  function automatic int exp_speed(input int i);
    int s;
    s = SPEED_INIT + points(i) / 100;
    return (s > SPEED_MAX) ? SPEED_MAX : s;
  endfunction

  function automatic bit rbit(input int n);
    return ($urandom_range(0, n - 1) == 0);
  endfunction

  task automatic model_step();
    bit press;
    press = btn_jump && !m_prev;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_state[i] = 0; m_ticks[i] = 0; m_hi[i] = 0; m_hold[i] = 0; m_sp[i] = 0;
      end else begin
        m_sp[i] = 0;
        case (m_state[i])
          0: if (press) begin m_state[i] = 1; m_ticks[i] = 0; m_sp[i] = 1; end
          1: begin
            if (hit) begin
              m_state[i] = 2;
              m_hold[i]  = 0;
              if (points(i) > m_hi[i]) m_hi[i] = points(i);
            end else if (frame_tick) begin
              m_ticks[i]++;
            end
          end
          default: begin
            if (press && m_hold[i] == OVER_HOLD) begin
              m_state[i] = 1; m_ticks[i] = 0; m_sp[i] = 1;
            end else if (frame_tick && m_hold[i] < OVER_HOLD) begin
              m_hold[i]++;
            end
          end
        endcase
      end
    end
    m_prev = rst ? 1'b0 : btn_jump;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    checkOutput("status_a", 32'(status_a), 32'(m_state[0] == 1));
    checkOutput("over_a",   32'(over_a),   32'(m_state[0] == 2));
    checkOutput("start_a",  32'(sp_a),     32'(m_sp[0]));
    checkOutput("score_a",  32'(score_a),  to_bcd(points(0)));
    checkOutput("hi_a",     32'(hi_a),     to_bcd(m_hi[0]));
    checkOutput("speed_a",  32'(speed_a),  exp_speed(0));
    checkOutput("status_b", 32'(status_b), 32'(m_state[1] == 1));
    checkOutput("over_b",   32'(over_b),   32'(m_state[1] == 2));
    checkOutput("start_b",  32'(sp_b),     32'(m_sp[1]));
    checkOutput("score_b",  32'(score_b),  to_bcd(points(1)));
    checkOutput("hi_b",     32'(hi_b),     to_bcd(m_hi[1]));
    checkOutput("speed_b",  32'(speed_b),  exp_speed(1));
  endtask

  task automatic applyStimulus(input bit r, input bit ft, input bit bj, input bit h);
    rst        = r;
    frame_tick = ft;
    btn_jump   = bj;
    hit        = h;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bit bj;
    rst = 1'b1; frame_tick = 1'b0; btn_jump = 1'b0; hit = 1'b0; m_prev = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_ticks[i] = 0; m_hi[i] = 0; m_hold[i] = 0; m_sp[i] = 0;
    end

    $display("[TB] reset and idle");
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, (i % 2) == 0, 1'b0, rbit(4));

    $display("[TB] start with held button, score, then hit on a scoring tick");
    repeat ($urandom_range(3, 8)) applyStimulus(1'b0, rbit(2), 1'b1, 1'b0);
    for (int i = 0; i < 400; i++) begin
      if (m_ticks[0] >= 18 && (m_ticks[0] % DIV_A) == DIV_A - 1) begin
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        break;
      end
      applyStimulus(1'b0, rbit(2), rbit(2), 1'b0);
    end

    $display("[TB] over hold-off with random presses");
    for (int i = 0; i < 150 && m_state[0] == 2; i++)
      applyStimulus(1'b0, rbit(2), rbit(2), rbit(3));

    $display("[TB] long run through speed ramp and score ceiling");
    repeat (40) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (10200) applyStimulus(1'b0, 1'b1, rbit(2), 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (40) applyStimulus(1'b0, rbit(2), rbit(2), rbit(2));

    $display("[TB] restart then reset mid-run");
    repeat (35) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (20) applyStimulus(1'b0, rbit(2), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] random traffic");
    bj = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (rbit(3)) bj = ~bj;
      applyStimulus(rbit(500), rbit(2), bj, rbit(40));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
